pipe_ctrl: RTL and testbench

Central stall/flush controller for the dual-issue pipeline. It merges per-stage stall requests into the 6-bit `stall` bus consumed by the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It sequences exception/ERET redirects: it drains any in-flight data-memory transaction, then issues a one-cycle `flush` with the redirect PC. It also keeps a stall-cycle performance counter and a stall watchdog.

---
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush controller: merges per-stage stall requests, sequences
// exception/ERET redirects (drain, then one-cycle flush), counts stalls, watchdog.
module pipe_ctrl #(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_exe,
  input  logic             stallreq_mem,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  input  logic             mem_busy,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wdog_err
);

  localparam int RUN_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t           state, state_next;
  logic [31:0]      target;
  logic [RUN_W-1:0] run_cnt;

  always_comb begin
    state_next = state;
    stall      = 6'b000000;
    case (state)
      IDLE: begin
        if (exc_req) begin
          // The faulting instruction must not advance while the redirect is set up.
          stall      = 6'b111111;
          state_next = mem_busy ? DRAIN : FLUSH;
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_exe) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      DRAIN: begin
        stall = 6'b111111;
        if (!mem_busy) state_next = FLUSH;
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      target   <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && exc_req) target <= exc_pc;
      flush <= (state_next == FLUSH);
      // Entering FLUSH straight from IDLE needs the PC of this cycle, not the stale target.
      if (state_next == FLUSH) flush_pc <= (state == IDLE) ? exc_pc : target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Run counter freezes once the watchdog has fired.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cnt  <= '0;
      wdog_err <= 1'b0;
    end else if (!wdog_err) begin
      if (stall != 6'b000000) begin
        run_cnt <= run_cnt + RUN_W'(1);
        if (run_cnt == RUN_W'(WDOG_LIMIT - 1)) wdog_err <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: stall merge, redirects, watchdog, async reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        resetn;
  logic        stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        mem_busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  stall_cnt;
  logic        wdog_err;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.WDOG_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_exe(stallreq_exe), .stallreq_mem(stallreq_mem),
    .exc_req(exc_req), .exc_pc(exc_pc), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .stall_cnt(stall_cnt), .wdog_err(wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_exe = 0; stallreq_mem = 0;
    exc_req = 0; exc_pc = 32'h0; mem_busy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    #7;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #3;
    checks++;
    if (flush !== 1'b0 || flush_pc !== 32'h0 || stall_cnt !== 4'd0 || wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: flush=%b flush_pc=%h cnt=%0d wdog=%b, required 0/0/0/0",
               flush, flush_pc, stall_cnt, wdog_err);
    end
    stallreq_id = 1;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL reset_merge: stall=%b required 000111", stall);
    end
    $display("reset: flush=%b cnt=%0d wdog=%b stall_in_reset=%b", flush, stall_cnt, wdog_err, stall);
    stallreq_id = 0;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_priority();
    logic [5:0] exp_tab [16];
    exp_tab = '{6'h00, 6'h03, 6'h07, 6'h07, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F};
    do_reset();
    mem_busy = 1;  // ignored in IDLE
    for (int i = 0; i < 16; i++) begin
      {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = 4'(i);
      #1;
      checks++;
      if (stall !== exp_tab[i]) begin
        errors++;
        $display("FAIL priority[%0d]: stall=%b required %b", i, stall, exp_tab[i]);
      end
      $display("priority: reqs=%b stall=%b", 4'(i), stall);
    end
    clear_inputs();
  endtask

  task automatic test_stall_merge();
    do_reset();
    stallreq_if = 1; stallreq_exe = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 6'b001111) begin
        errors++;
        $display("FAIL merge_stall[%0d]: stall=%b required 001111", i, stall);
      end
      step();
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL merge_cnt: stall_cnt=%0d required 3", stall_cnt);
    end
    stallreq_if = 0; stallreq_exe = 0;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      errors++;
      $display("FAIL merge_drop: stall=%b required 000000", stall);
    end
    step();
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL merge_hold: stall_cnt=%0d required 3", stall_cnt);
    end
    $display("merge: stall_cnt=%0d after drop", stall_cnt);
  endtask

  task automatic test_exc_no_drain();
    do_reset();
    exc_req = 1; exc_pc = 32'hBFC00380; mem_busy = 0; stallreq_if = 1;
    #1;
    checks++;
    if (stall !== 6'b111111 || flush !== 1'b0) begin
      errors++;
      $display("FAIL exc_n: stall=%b flush=%b required 111111/0", stall, flush);
    end
    step();
    exc_req = 0; exc_pc = 32'h12345678; stallreq_if = 0;
    #1;
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'hBFC00380 || stall !== 6'b000000) begin
      errors++;
      $display("FAIL exc_n1: flush=%b flush_pc=%h stall=%b required 1/bfc00380/000000",
               flush, flush_pc, stall);
    end
    step();
    checks++;
    if (flush !== 1'b0 || flush_pc !== 32'hBFC00380) begin
      errors++;
      $display("FAIL exc_n2: flush=%b flush_pc=%h required 0/bfc00380", flush, flush_pc);
    end
    $display("exc_no_drain: flush_pc=%h", flush_pc);
  endtask

  task automatic test_exc_drain();
    logic busy_tab [6];
    logic exc_tab  [6];
    busy_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exc_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c < 6) begin
        mem_busy = busy_tab[c];
        exc_req  = exc_tab[c];
        exc_pc   = (c == 0) ? 32'hBFC00380 : 32'h0;
      end else begin
        clear_inputs();
      end
      #1;
      checks++;
      if (c <= 4) begin
        if (stall !== 6'b111111 || flush !== 1'b0) begin
          errors++;
          $display("FAIL drain_n%0d: stall=%b flush=%b required 111111/0", c, stall, flush);
        end
      end else if (c == 5) begin
        if (flush !== 1'b1 || flush_pc !== 32'hBFC00380 || stall !== 6'b000000) begin
          errors++;
          $display("FAIL drain_n5: flush=%b flush_pc=%h stall=%b required 1/bfc00380/000000",
                   flush, flush_pc, stall);
        end
      end else begin
        if (flush !== 1'b0) begin
          errors++;
          $display("FAIL drain_n6: flush=%b required 0", flush);
        end
      end
      $display("drain: cycle N+%0d stall=%b flush=%b flush_pc=%h", c, stall, flush, flush_pc);
      step();
    end
    clear_inputs();
  endtask

  task automatic test_flush_requests();
    do_reset();
    exc_req = 1; exc_pc = 32'h80000180;
    step();
    exc_req = 1; exc_pc = 32'hDEAD0000; stallreq_mem = 1;
    #1;
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b1 || flush_pc !== 32'h80000180) begin
      errors++;
      $display("FAIL flushreq_f: stall=%b flush=%b flush_pc=%h required 000000/1/80000180",
               stall, flush, flush_pc);
    end
    step();
    exc_req = 0;
    #1;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b011111) begin
      errors++;
      $display("FAIL flushreq_next: flush=%b stall=%b required 0/011111", flush, stall);
    end
    step();
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL flushreq_again: flush=%b required 0", flush);
    end
    $display("flush_requests: stall=%b flush=%b", stall, flush);
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    stallreq_id = 1;
    repeat (7) step();
    stallreq_id = 0;
    step();
    checks++;
    if (wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_7: wdog_err=%b required 0", wdog_err);
    end
    stallreq_id = 1;
    repeat (7) step();
    checks++;
    if (wdog_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_pre: wdog_err=%b required 0", wdog_err);
    end
    step();
    checks++;
    if (wdog_err !== 1'b1 || stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wdog_8: wdog_err=%b stall_cnt=%0d required 1/15", wdog_err, stall_cnt);
    end
    stallreq_id = 0;
    step();
    checks++;
    if (wdog_err !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky: wdog_err=%b required 1", wdog_err);
    end
    stallreq_id = 1;
    repeat (3) step();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL cnt_sat: stall_cnt=%0d required 15", stall_cnt);
    end
    $display("watchdog: wdog_err=%b stall_cnt=%0d", wdog_err, stall_cnt);
    clear_inputs();
  endtask

  task automatic test_reset_drain();
    bit flush_seen;
    do_reset();
    exc_req = 1; exc_pc = 32'hA0000000; mem_busy = 1;
    step();
    exc_req = 0;
    step();
    step();
    checks++;
    if (stall_cnt !== 4'd3 || stall !== 6'b111111) begin
      errors++;
      $display("FAIL rdrain_pre: stall_cnt=%0d stall=%b required 3/111111", stall_cnt, stall);
    end
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || stall_cnt !== 4'd0 || wdog_err !== 1'b0 || stall !== 6'b000000) begin
      errors++;
      $display("FAIL rdrain_async: flush=%b cnt=%0d wdog=%b stall=%b required 0/0/0/000000",
               flush, stall_cnt, wdog_err, stall);
    end
    mem_busy = 0;
    @(negedge clk);
    resetn = 1'b1;
    flush_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (flush !== 1'b0 || stall !== 6'b000000) flush_seen = 1;
    end
    checks++;
    if (flush_seen) begin
      errors++;
      $display("FAIL rdrain_post: flush or stall activity after release, required none");
    end
    $display("reset_drain: flush=%b stall=%b after release", flush, stall);
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b1;
    test_reset();
    test_priority();
    test_stall_merge();
    test_exc_no_drain();
    test_exc_drain();
    test_flush_requests();
    test_watchdog();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
